// File: rtl/settings_pkg.sv
// settings_pkg: shared types for the matrix-settings register file.
//   field_addr_e : shadow field selector carried on wr_addr
//   err_code_e   : commit rejection reason, in check-priority order
//   state_e      : commit FSM states
//   CFG_GEN_W    : width of the successful-apply counter
package settings_pkg;

    localparam int CFG_GEN_W = 8;

    typedef enum logic [1:0] {
        FLD_ROW = 2'd0,
        FLD_COL = 2'd1,
        FLD_MIN = 2'd2,
        FLD_MAX = 2'd3
    } field_addr_e;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'd0,
        ERR_ROW    = 2'd1,
        ERR_COL    = 2'd2,
        ERR_BOUNDS = 2'd3
    } err_code_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_APPLY  = 2'd2,
        ST_REJECT = 2'd3
    } state_e;

endpackage

// File: rtl/settings_checker.sv
// settings_checker: combinational legality check of a staged configuration.
//   row, col            : dimensions, unsigned, legal range 1..MAX_DIM
//   data_min, data_max  : element bounds, signed, data_min <= data_max
//   pass                : all checks satisfied
//   err_code            : first failing check (row, then col, then bounds)
module settings_checker
    import settings_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int MAX_DIM = 32
) (
    input  logic [DATA_W-1:0] row,
    input  logic [DATA_W-1:0] col,
    input  logic [DATA_W-1:0] data_min,
    input  logic [DATA_W-1:0] data_max,
    output logic              pass,
    output err_code_e         err_code
);

    localparam logic [DATA_W-1:0] MAX_DIM_V = DATA_W'(MAX_DIM);

    function automatic logic dim_ok(input logic [DATA_W-1:0] v);
        return (v != {DATA_W{1'b0}}) && (v <= MAX_DIM_V);
    endfunction

    // Priority-ordered checks: the earliest failing field determines the code.
    always_comb begin
        pass     = 1'b0;
        err_code = ERR_NONE;
        if (!dim_ok(row)) begin
            err_code = ERR_ROW;
        end else if (!dim_ok(col)) begin
            err_code = ERR_COL;
        end else if ($signed(data_min) > $signed(data_max)) begin
            err_code = ERR_BOUNDS;
        end else begin
            pass = 1'b1;
        end
    end

endmodule

// File: rtl/settings_regfile.sv
// settings_regfile: staged matrix-settings registers with validated commit.
// Host writes land in shadow registers; a commit request runs a range check
// and either copies the shadow set to the active set in one edge or restores
// the shadow set from the active one and reports an error code.
//   wr_valid/wr_ready/wr_addr/wr_data : shadow field write (IDLE only)
//   commit_req                        : validate-and-apply request (IDLE only)
//   commit_done                       : one-cycle completion pulse
//   commit_ok, err_code               : result of the last commit
//   busy                              : commit in progress
//   cfg_gen                           : count of successful applies (wraps)
//   rd_max_row/rd_max_col/rd_data_min/rd_data_max : active configuration
module settings_regfile
    import settings_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int MAX_DIM = 32,
    parameter int DEF_ROW = 5,
    parameter int DEF_COL = 5,
    parameter int DEF_MIN = 1,
    parameter int DEF_MAX = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [1:0]           wr_addr,
    input  logic [DATA_W-1:0]    wr_data,
    input  logic                 commit_req,
    output logic                 commit_done,
    output logic                 commit_ok,
    output logic [1:0]           err_code,
    output logic                 busy,
    output logic [CFG_GEN_W-1:0] cfg_gen,
    output logic [DATA_W-1:0]    rd_max_row,
    output logic [DATA_W-1:0]    rd_max_col,
    output logic [DATA_W-1:0]    rd_data_min,
    output logic [DATA_W-1:0]    rd_data_max
);

    localparam logic [DATA_W-1:0] DEF_ROW_V = DATA_W'(DEF_ROW);
    localparam logic [DATA_W-1:0] DEF_COL_V = DATA_W'(DEF_COL);
    localparam logic [DATA_W-1:0] DEF_MIN_V = DATA_W'(DEF_MIN);
    localparam logic [DATA_W-1:0] DEF_MAX_V = DATA_W'(DEF_MAX);

    state_e                 state_r;
    logic [DATA_W-1:0]      sh_row_r, sh_col_r, sh_min_r, sh_max_r;
    logic [DATA_W-1:0]      act_row_r, act_col_r, act_min_r, act_max_r;
    logic                   wr_ready_r, busy_r, commit_done_r, commit_ok_r;
    err_code_e              err_code_r;
    err_code_e              chk_err_r;
    logic [CFG_GEN_W-1:0]   cfg_gen_r;

    logic                   chk_pass_s;
    err_code_e              chk_err_s;

    settings_checker #(
        .DATA_W  (DATA_W),
        .MAX_DIM (MAX_DIM)
    ) u_checker (
        .row      (sh_row_r),
        .col      (sh_col_r),
        .data_min (sh_min_r),
        .data_max (sh_max_r),
        .pass     (chk_pass_s),
        .err_code (chk_err_s)
    );

    // Commit FSM plus shadow/active register file; all outputs come from here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            sh_row_r      <= DEF_ROW_V;
            sh_col_r      <= DEF_COL_V;
            sh_min_r      <= DEF_MIN_V;
            sh_max_r      <= DEF_MAX_V;
            act_row_r     <= DEF_ROW_V;
            act_col_r     <= DEF_COL_V;
            act_min_r     <= DEF_MIN_V;
            act_max_r     <= DEF_MAX_V;
            wr_ready_r    <= 1'b1;
            busy_r        <= 1'b0;
            commit_done_r <= 1'b0;
            commit_ok_r   <= 1'b1;
            err_code_r    <= ERR_NONE;
            chk_err_r     <= ERR_NONE;
            cfg_gen_r     <= {CFG_GEN_W{1'b0}};
        end else begin
            commit_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // A write in the same cycle as commit_req lands first, so the
                    // checker sees it during CHECK.
                    if (wr_valid) begin
                        case (field_addr_e'(wr_addr))
                            FLD_ROW: sh_row_r <= wr_data;
                            FLD_COL: sh_col_r <= wr_data;
                            FLD_MIN: sh_min_r <= wr_data;
                            FLD_MAX: sh_max_r <= wr_data;
                            default: sh_row_r <= sh_row_r;
                        endcase
                    end
                    if (commit_req) begin
                        state_r    <= ST_CHECK;
                        busy_r     <= 1'b1;
                        wr_ready_r <= 1'b0;
                    end
                end
                ST_CHECK: begin
                    chk_err_r <= chk_err_s;
                    state_r   <= chk_pass_s ? ST_APPLY : ST_REJECT;
                end
                ST_APPLY: begin
                    act_row_r     <= sh_row_r;
                    act_col_r     <= sh_col_r;
                    act_min_r     <= sh_min_r;
                    act_max_r     <= sh_max_r;
                    cfg_gen_r     <= cfg_gen_r + CFG_GEN_W'(1);
                    commit_ok_r   <= 1'b1;
                    err_code_r    <= ERR_NONE;
                    commit_done_r <= 1'b1;
                    busy_r        <= 1'b0;
                    wr_ready_r    <= 1'b1;
                    state_r       <= ST_IDLE;
                end
                ST_REJECT: begin
                    // Discard staged writes so the next commit starts from the
                    // configuration that is actually live.
                    sh_row_r      <= act_row_r;
                    sh_col_r      <= act_col_r;
                    sh_min_r      <= act_min_r;
                    sh_max_r      <= act_max_r;
                    commit_ok_r   <= 1'b0;
                    err_code_r    <= chk_err_r;
                    commit_done_r <= 1'b1;
                    busy_r        <= 1'b0;
                    wr_ready_r    <= 1'b1;
                    state_r       <= ST_IDLE;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    busy_r     <= 1'b0;
                    wr_ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign wr_ready    = wr_ready_r;
    assign busy        = busy_r;
    assign commit_done = commit_done_r;
    assign commit_ok   = commit_ok_r;
    assign err_code    = err_code_r;
    assign cfg_gen     = cfg_gen_r;
    assign rd_max_row  = act_row_r;
    assign rd_max_col  = act_col_r;
    assign rd_data_min = act_min_r;
    assign rd_data_max = act_max_r;

endmodule

// File: tb/tb_settings_regfile.sv
// tb_settings_regfile: scoreboard bench for settings_regfile. Each commit pushes
// the expected result (from a small shadow/active model) when it is issued; the
// entry is popped and compared when commit_done is observed.
module tb_settings_regfile;
    import settings_pkg::*;

    localparam int MD = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic [1:0]  wr_addr = 2'd0;
    logic [31:0] wr_data = 32'd0;
    logic        commit_req = 1'b0;
    logic        wr_ready, commit_done, commit_ok, busy;
    logic [1:0]  err_code;
    logic [7:0]  cfg_gen;
    logic [31:0] rd_max_row, rd_max_col, rd_data_min, rd_data_max;

    settings_regfile dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .commit_req  (commit_req),
        .commit_done (commit_done),
        .commit_ok   (commit_ok),
        .err_code    (err_code),
        .busy        (busy),
        .cfg_gen     (cfg_gen),
        .rd_max_row  (rd_max_row),
        .rd_max_col  (rd_max_col),
        .rd_data_min (rd_data_min),
        .rd_data_max (rd_data_max)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        ok;
        logic [1:0]  err;
        logic [31:0] row;
        logic [31:0] col;
        logic [31:0] mn;
        logic [31:0] mx;
        logic [7:0]  gen;
        logic [7:0]  lat;
    } res_t;

    res_t        sb_q[$];
    logic [31:0] sh_m[4];
    logic [31:0] act_m[4];
    logic [7:0]  gen_m;
    int          tests = 0;
    int          fails = 0;

    function automatic logic [1:0] model_check();
        if (sh_m[0] == 32'd0 || sh_m[0] > 32'(MD)) return 2'd1;
        if (sh_m[1] == 32'd0 || sh_m[1] > 32'(MD)) return 2'd2;
        if ($signed(sh_m[2]) > $signed(sh_m[3])) return 2'd3;
        return 2'd0;
    endfunction

    task automatic model_reset();
        sh_m[0] = 32'd5; sh_m[1] = 32'd5; sh_m[2] = 32'd1; sh_m[3] = 32'd9;
        for (int i = 0; i < 4; i++) act_m[i] = sh_m[i];
        gen_m = 8'd0;
        sb_q.delete();
    endtask

    // Apply the model for one commit and push its expected visible result.
    task automatic push_expect();
        logic [1:0] e;
        e = model_check();
        if (e == 2'd0) begin
            for (int i = 0; i < 4; i++) act_m[i] = sh_m[i];
            gen_m = gen_m + 8'd1;
        end else begin
            for (int i = 0; i < 4; i++) sh_m[i] = act_m[i];
        end
        sb_q.push_back({(e == 2'd0), e, act_m[0], act_m[1], act_m[2], act_m[3], gen_m, 8'd3});
    endtask

    task automatic write_field(input logic [1:0] a, input logic [31:0] d,
                               output int cyc, output bit done_seen);
        bit acc;
        acc = 1'b0; cyc = 0; done_seen = 1'b0;
        wr_valid = 1'b1; wr_addr = a; wr_data = d;
        while (!acc && cyc < 20) begin
            acc = wr_ready;
            @(posedge clk); #1;
            cyc++;
            if (commit_done) done_seen = 1'b1;
        end
        wr_valid = 1'b0;
        tests++;
        if (!acc) begin
            fails++;
            $display("FAIL write_accept addr=%0d got wr_ready never high, required accept within 20 cycles", a);
        end else begin
            sh_m[a] = d;
        end
    endtask

    task automatic issue_commit();
        push_expect();
        commit_req = 1'b1;
        @(posedge clk); #1;
        commit_req = 1'b0;
    endtask

    // Counts edges from the commit_req edge until commit_done is seen.
    task automatic wait_done(output int lat);
        lat = 1;
        while (!commit_done && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({rd_max_row, rd_max_col, rd_data_min, rd_data_max} !== {32'd5, 32'd5, 32'd1, 32'd9}) begin
            fails++;
            $display("FAIL reset_cfg got=%h required=%h",
                     {rd_max_row, rd_max_col, rd_data_min, rd_data_max}, {32'd5, 32'd5, 32'd1, 32'd9});
        end
        tests++;
        if ({cfg_gen, commit_ok, err_code, busy, wr_ready, commit_done} !== {8'd0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL reset_status got=%h required=%h",
                     {cfg_gen, commit_ok, err_code, busy, wr_ready, commit_done},
                     {8'd0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic commit_and_check(input string name);
        int   lat;
        res_t got, exp;
        issue_commit();
        wait_done(lat);
        got = {commit_ok, err_code, rd_max_row, rd_max_col, rd_data_min, rd_data_max, cfg_gen, 8'(lat)};
        exp = sb_q.pop_front();
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h required=%h", name, got, exp);
        end
    endtask

    task automatic test_apply();
        int c; bit d;
        write_field(2'd0, 32'd8, c, d);
        write_field(2'd1, 32'd12, c, d);
        write_field(2'd2, -32'sd3, c, d);
        write_field(2'd3, 32'd20, c, d);
        commit_and_check("apply_basic");
    endtask

    task automatic test_reject_row();
        int c; bit d;
        write_field(2'd0, 32'd0, c, d);
        commit_and_check("reject_row");
        commit_and_check("after_reject_restore");
    endtask

    task automatic test_priority();
        int c; bit d;
        write_field(2'd1, 32'(MD + 1), c, d);
        write_field(2'd2, 32'd10, c, d);
        write_field(2'd3, 32'd2, c, d);
        commit_and_check("priority_col_over_bounds");
        write_field(2'd2, 32'd10, c, d);
        write_field(2'd3, 32'd2, c, d);
        commit_and_check("reject_bounds");
        write_field(2'd0, 32'(MD), c, d);
        write_field(2'd1, 32'(MD), c, d);
        write_field(2'd2, 32'd7, c, d);
        write_field(2'd3, 32'd7, c, d);
        commit_and_check("equal_bounds_max_dims");
    endtask

    task automatic test_same_cycle();
        int   lat;
        res_t got, exp;
        wr_valid = 1'b1; wr_addr = 2'd0; wr_data = 32'd4;
        sh_m[0] = 32'd4;
        push_expect();
        commit_req = 1'b1;
        @(posedge clk); #1;
        commit_req = 1'b0; wr_valid = 1'b0;
        wait_done(lat);
        got = {commit_ok, err_code, rd_max_row, rd_max_col, rd_data_min, rd_data_max, cfg_gen, 8'(lat)};
        exp = sb_q.pop_front();
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL same_cycle_write got=%h required=%h", got, exp);
        end
    endtask

    task automatic test_stall();
        int   c; bit d;
        res_t got, exp;
        issue_commit();
        write_field(2'd0, 32'd6, c, d);
        tests++;
        if ({8'(c), d} !== {8'd3, 1'b1}) begin
            fails++;
            $display("FAIL stall_timing got cycles=%0d done=%0d required cycles=3 done=1", c, d);
        end
        got = {commit_ok, err_code, rd_max_row, rd_max_col, rd_data_min, rd_data_max, cfg_gen, 8'd3};
        exp = sb_q.pop_front();
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL stall_commit got=%h required=%h", got, exp);
        end
        commit_and_check("stalled_write_applied");
    endtask

    task automatic test_busy_ignore();
        res_t got, exp;
        int   extra;
        push_expect();
        commit_req = 1'b1;
        @(posedge clk); #1;
        tests++;
        if ({busy, wr_ready} !== {1'b1, 1'b0}) begin
            fails++;
            $display("FAIL busy_flags got busy=%0b ready=%0b required busy=1 ready=0", busy, wr_ready);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        commit_req = 1'b0;
        got = {commit_ok, err_code, rd_max_row, rd_max_col, rd_data_min, rd_data_max, cfg_gen, 8'(commit_done ? 3 : 0)};
        exp = sb_q.pop_front();
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL busy_commit got=%h required=%h", got, exp);
        end
        extra = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (commit_done) extra++;
        end
        tests++;
        if (extra !== 0) begin
            fails++;
            $display("FAIL busy_req_ignored got extra_done=%0d required 0", extra);
        end
    endtask

    task automatic test_reset_mid();
        int c; bit d; int seen;
        write_field(2'd0, 32'd10, c, d);
        issue_commit();
        rst_n = 1'b0;
        model_reset();
        #2;
        tests++;
        if ({rd_max_row, rd_max_col, rd_data_min, rd_data_max, cfg_gen, commit_ok, err_code, busy, wr_ready, commit_done}
            !== {32'd5, 32'd5, 32'd1, 32'd9, 8'd0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL reset_mid_defaults got row=%0d col=%0d gen=%0d ok=%0b busy=%0b ready=%0b required 5 5 0 1 0 1",
                     rd_max_row, rd_max_col, cfg_gen, commit_ok, busy, wr_ready);
        end
        rst_n = 1'b1;
        seen = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (commit_done) seen++;
        end
        tests++;
        if (seen !== 0) begin
            fails++;
            $display("FAIL reset_mid_no_done got done=%0d required 0", seen);
        end
        commit_and_check("reset_mid_shadow_cleared");
    endtask

    task automatic test_wrap();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 256; i++) commit_and_check("wrap_commit");
        tests++;
        if (cfg_gen !== 8'd0) begin
            fails++;
            $display("FAIL cfg_gen_wrap got=%0d required=0", cfg_gen);
        end
    endtask

    initial begin
        test_reset();
        test_apply();
        test_reject_row();
        test_priority();
        test_same_cycle();
        test_stall();
        test_busy_ignore();
        test_reset_mid();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
